// File: rtl/addr_seq_pkg.sv
// Shared definitions for the register/bit address sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: sequencer state encoding and the counter-width derivation
// used by the interface, the top and the bench.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Counter width is the register field followed by the bit field.
    function automatic int cw_of(input int rg_w, input int bit_w);
        return rg_w + bit_w;
    endfunction

endpackage

// File: rtl/addr_seq_if.sv
// Control/address bundle between the step source and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle and always accepted.
//
// master: step source / front panel (drives tick, strobes, load value)
// slave : sequencer (drives rg_a, bit_a, busy, done, wrap)
interface addr_seq_if #(
    parameter int RG_W  = 4,
    parameter int BIT_W = 2
);
    import addr_seq_pkg::*;

    localparam int CW = cw_of(RG_W, BIT_W);

    logic              tick;
    logic              start;
    logic              stop;
    logic              dir;
    logic              oneshot;
    logic              load;
    logic [CW-1:0]     load_val;
    logic [RG_W-1:0]   rg_a;
    logic [BIT_W-1:0]  bit_a;
    logic              busy;
    logic              done;
    logic              wrap;

    modport master (
        output tick, start, stop, dir, oneshot, load, load_val,
        input  rg_a, bit_a, busy, done, wrap
    );

    modport slave (
        input  tick, start, stop, dir, oneshot, load, load_val,
        output rg_a, bit_a, busy, done, wrap
    );

endinterface

// File: rtl/addr_seq_tick_edge.sv
// Optional 2-FF synchroniser plus rising-edge detector for the step input.
// Latency: step_o high during the cycle after 2 edges (SYNC=1) or 0 edges (SYNC=0).
// Backpressure: none; one step per rising edge, edges closer than 2 low cycles may merge.
//
// Ports: clk, clr (async, active-high), tick_i (raw step level), step_o (one-cycle pulse).
module addr_seq_tick_edge #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic tick_i,
    output logic step_o
);

    logic tick_s;
    logic prev_q;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], tick_i};
                end
            end
            assign tick_s = sync_q[1];
        end else begin : g_nosync
            assign tick_s = tick_i;
        end
    endgenerate

    // History clears to 0, so a level already high after reset produces one
    // step; the sequencer is in IDLE then and discards it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= tick_s;
        end
    end

    assign step_o = tick_s & ~prev_q;

endmodule

// File: rtl/addr_seq.sv
// Register/bit address sequencer: steps {rg_a, bit_a} over 0..LIMIT on each tick.
// Latency: strobes act on the next clk edge; tick to counter is 3 edges (SYNC=1) or 1 (SYNC=0).
// Backpressure: none; ticks coinciding with start/stop/load are dropped, not deferred.
//
// Ports: clk, clr (async, active-high), sq (slave side of addr_seq_if:
// tick/start/stop/dir/oneshot/load/load_val in; rg_a/bit_a/busy/done/wrap out).
module addr_seq
    import addr_seq_pkg::*;
#(
    parameter int RG_W  = 4,
    parameter int BIT_W = 2,
    parameter int LIMIT = (1 << (RG_W + BIT_W)) - 1,
    parameter bit SYNC  = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    addr_seq_if.slave  sq
);

    localparam int            CW  = cw_of(RG_W, BIT_W);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            wrap_q;
    logic            dir_q;
    logic            os_q;

    logic            step;
    logic            at_end;
    logic [CW-1:0]   cnt_step_d;
    logic [CW-1:0]   load_clamped;

    addr_seq_tick_edge #(.SYNC(SYNC)) u_tick_edge (
        .clk    (clk),
        .clr    (clr),
        .tick_i (sq.tick),
        .step_o (step)
    );

    // Loads above the terminal count saturate so the range is never left.
    assign load_clamped = (sq.load_val > LIM) ? LIM : sq.load_val;

    // Next counter value for a tick step, including the wrap to the far end.
    always_comb begin
        at_end     = dir_q ? (cnt_q == '0) : (cnt_q == LIM);
        cnt_step_d = cnt_q;
        if (dir_q) begin
            cnt_step_d = at_end ? LIM : (cnt_q - CW'(1));
        end else begin
            cnt_step_d = at_end ? '0 : (cnt_q + CW'(1));
        end
    end

    // Priority: stop > start (outside RUN) > load > tick step.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dir_q   <= 1'b0;
            os_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (sq.stop) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (sq.start && (state_q != S_RUN)) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                dir_q   <= sq.dir;
                os_q    <= sq.oneshot;
                // A simultaneous load replaces the direction-dependent restart value.
                if (sq.load) begin
                    cnt_q <= load_clamped;
                end else begin
                    cnt_q <= sq.dir ? LIM : '0;
                end
            end else if (sq.load) begin
                cnt_q <= load_clamped;
            end else if (step && (state_q == S_RUN) && !sq.start) begin
                // A start ignored in RUN still swallows a coincident tick.
                if (at_end && os_q) begin
                    state_q <= S_HOLD;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    cnt_q  <= cnt_step_d;
                    wrap_q <= at_end;
                end
            end
        end
    end

    assign sq.rg_a  = cnt_q[CW-1:BIT_W];
    assign sq.bit_a = cnt_q[BIT_W-1:0];
    assign sq.busy  = busy_q;
    assign sq.done  = done_q;
    assign sq.wrap  = wrap_q;

endmodule

// File: tb/tb_addr_seq.sv
module tb_addr_seq;

    logic clk;
    logic clr;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries pack {done, busy, wrap, count[5:0]}.
    logic [8:0] exp_q[$];

    addr_seq_if #(.RG_W(4), .BIT_W(2)) ifa ();
    addr_seq_if #(.RG_W(4), .BIT_W(2)) ifb ();

    // A: default range 0..0x3F, synchronised tick.
    addr_seq #(.RG_W(4), .BIT_W(2), .SYNC(1'b1)) dut_a (
        .clk (clk),
        .clr (clr),
        .sq  (ifa)
    );

    // B: range 0..0x17, tick already synchronous.
    addr_seq #(.RG_W(4), .BIT_W(2), .LIMIT(8'h17), .SYNC(1'b0)) dut_b (
        .clk (clk),
        .clr (clr),
        .sq  (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] pk(input logic d, input logic b, input logic w, input logic [5:0] c);
        return {d, b, w, c};
    endfunction

    function automatic logic [8:0] obs_a();
        return {ifa.done, ifa.busy, ifa.wrap, ifa.rg_a, ifa.bit_a};
    endfunction

    function automatic logic [8:0] obs_b();
        return {ifb.done, ifb.busy, ifb.wrap, ifb.rg_a, ifb.bit_a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Synchronised tick: counter moves on the third edge after the rise.
    task automatic tick_a_chk(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        exp_q.push_back(exp);
        ifa.tick = 1'b1;
        cyc();
        cyc();
        ifa.tick = 1'b0;
        cyc();
        e = exp_q.pop_front();
        chk(tag, obs_a(), e);
        cyc();
    endtask

    // Unsynchronised tick: counter moves on the first edge after the rise.
    task automatic tick_b_chk(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        exp_q.push_back(exp);
        ifb.tick = 1'b1;
        cyc();
        ifb.tick = 1'b0;
        e = exp_q.pop_front();
        chk(tag, obs_b(), e);
        cyc();
        cyc();
    endtask

    initial begin
        clr = 1'b1;
        ifa.tick = 0; ifa.start = 0; ifa.stop = 0; ifa.dir = 0; ifa.oneshot = 0;
        ifa.load = 0; ifa.load_val = '0;
        ifb.tick = 0; ifb.start = 0; ifb.stop = 0; ifb.dir = 0; ifb.oneshot = 0;
        ifb.load = 0; ifb.load_val = '0;
        cyc();
        cyc();
        chk("reset_a", obs_a(), pk(0, 0, 0, 6'h00));
        chk("reset_b", obs_b(), pk(0, 0, 0, 6'h00));
        clr = 1'b0;
        cyc();

        // Up wrap over the full default range.
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
        chk("upwrap_start", obs_a(), pk(0, 1, 0, 6'h00));
        for (int i = 1; i <= 64; i++) begin
            tick_a_chk("upwrap_step", pk(0, 1, (i == 64), 6'(i % 64)));
        end
        chk("upwrap_pulse_end", obs_a(), pk(0, 1, 0, 6'h00));

        // Walk to 0x2A, then reset asynchronously with tick held high.
        for (int i = 1; i <= 42; i++) begin
            tick_a_chk("walk_2a", pk(0, 1, 0, 6'(i)));
        end
        chk("at_2a", obs_a(), pk(0, 1, 0, 6'h2A));
        ifa.tick = 1'b1;
        #2;
        clr = 1'b1;
        #1;
        chk("clr_immediate", obs_a(), pk(0, 0, 0, 6'h00));
        cyc();
        cyc();
        clr = 1'b0;
        repeat (4) cyc();
        chk("clr_idle_tick_high", obs_a(), pk(0, 0, 0, 6'h00));
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
        repeat (3) cyc();
        chk("held_tick_no_step", obs_a(), pk(0, 1, 0, 6'h00));
        ifa.tick = 1'b0;
        cyc();
        cyc();

        // Stop coinciding with a step at 0x0A.
        for (int i = 1; i <= 10; i++) begin
            tick_a_chk("walk_0a", pk(0, 1, 0, 6'(i)));
        end
        ifa.tick = 1'b1;
        cyc();
        cyc();
        ifa.stop = 1'b1;
        cyc();
        ifa.stop = 1'b0;
        ifa.tick = 1'b0;
        chk("stop_vs_tick", obs_a(), pk(0, 0, 0, 6'h0A));
        cyc();
        tick_a_chk("idle_ignores_1", pk(0, 0, 0, 6'h0A));
        tick_a_chk("idle_ignores_2", pk(0, 0, 0, 6'h0A));

        // Latency with synchroniser: change lands on the third edge.
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
        ifa.tick = 1'b1;
        cyc();
        chk("lat_sync_e1", obs_a(), pk(0, 1, 0, 6'h00));
        cyc();
        chk("lat_sync_e2", obs_a(), pk(0, 1, 0, 6'h00));
        ifa.tick = 1'b0;
        cyc();
        chk("lat_sync_e3", obs_a(), pk(0, 1, 0, 6'h01));
        cyc();

        // Down one-shot on LIMIT=0x17; first step also shows 1-edge latency.
        ifb.dir = 1'b1;
        ifb.oneshot = 1'b1;
        ifb.start = 1'b1;
        cyc();
        ifb.start = 1'b0;
        ifb.dir = 1'b0;
        ifb.oneshot = 1'b0;
        chk("down_start", obs_b(), pk(0, 1, 0, 6'h17));
        for (int k = 1; k <= 23; k++) begin
            tick_b_chk("down_step", pk(0, 1, 0, 6'(23 - k)));
        end
        tick_b_chk("down_hold", pk(1, 0, 0, 6'h00));
        tick_b_chk("hold_ignores_1", pk(1, 0, 0, 6'h00));
        tick_b_chk("hold_ignores_2", pk(1, 0, 0, 6'h00));

        // Load clamp in HOLD, then start+load together.
        ifb.load = 1'b1;
        ifb.load_val = 6'h30;
        cyc();
        ifb.load = 1'b0;
        chk("load_clamp", obs_b(), pk(1, 0, 0, 6'h17));
        ifb.start = 1'b1;
        ifb.load = 1'b1;
        ifb.load_val = 6'h05;
        cyc();
        ifb.start = 1'b0;
        ifb.load = 1'b0;
        chk("start_load", obs_b(), pk(0, 1, 0, 6'h05));
        tick_b_chk("after_start_load", pk(0, 1, 0, 6'h06));

        // Up wrap at a reduced limit.
        ifb.load = 1'b1;
        ifb.load_val = 6'h16;
        cyc();
        ifb.load = 1'b0;
        tick_b_chk("b_to_limit", pk(0, 1, 0, 6'h17));
        tick_b_chk("b_wrap", pk(0, 1, 1, 6'h00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
